// File: rtl/io_controller.sv
// Memory-mapped I/O peripheral on the MEM-stage bus: output register, synchronised
// inputs with sticky rising-edge flags, and a free-running timer with a compare flag.
module io_controller #(
   parameter int               XLEN      = 32,
   parameter int               IO_WIDTH  = 11,
   parameter logic [XLEN-1:0]  BASE_ADDR = 32'h0000_0400
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [XLEN-1:0]     address,
   input  logic [XLEN-1:0]     write_data,
   input  logic                write_enable,
   output logic [XLEN-1:0]     read_data,
   output logic                hit,
   input  logic [IO_WIDTH-1:0] io_input_bus,
   output logic [IO_WIDTH-1:0] io_output_bus,
   output logic                timer_irq
);

   localparam logic [2:0] IDX_OUT    = 3'd0;
   localparam logic [2:0] IDX_IN     = 3'd1;
   localparam logic [2:0] IDX_EDGE   = 3'd2;
   localparam logic [2:0] IDX_TIMER  = 3'd3;
   localparam logic [2:0] IDX_CMP    = 3'd4;
   localparam logic [2:0] IDX_STATUS = 3'd5;

   logic                in_window;
   logic [2:0]          idx;
   logic                wr;
   logic                unused_addr_bits;

   logic [IO_WIDTH-1:0] out_reg;
   logic [IO_WIDTH-1:0] sync1;
   logic [IO_WIDTH-1:0] sync2;
   logic [IO_WIDTH-1:0] prev;
   logic [IO_WIDTH-1:0] edge_flags;
   logic [IO_WIDTH-1:0] rise;
   logic [IO_WIDTH-1:0] edge_clear;
   logic [XLEN-1:0]     timer;
   logic [XLEN-1:0]     cmp;
   logic                match;
   logic                match_now;
   logic                match_clear;
   logic [XLEN-1:0]     rd_mux;

   assign in_window        = (address[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
   assign idx              = address[4:2];
   assign wr               = write_enable & in_window;
   // Word access only: the byte offset within a word is deliberately ignored.
   assign unused_addr_bits = &address[1:0];

   assign io_output_bus = out_reg;
   assign timer_irq     = match;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      rise        = sync2 & ~prev;
      edge_clear  = '0;
      match_clear = 1'b0;
      match_now   = (timer == cmp);
      if (wr && idx == IDX_EDGE)   edge_clear  = write_data[IO_WIDTH-1:0];
      if (wr && idx == IDX_STATUS) match_clear = write_data[0];
   end

   always_comb begin
      rd_mux = '0;
      if (in_window) begin
         case (idx)
            IDX_OUT:    rd_mux = {{(XLEN-IO_WIDTH){1'b0}}, out_reg};
            IDX_IN:     rd_mux = {{(XLEN-IO_WIDTH){1'b0}}, sync2};
            IDX_EDGE:   rd_mux = {{(XLEN-IO_WIDTH){1'b0}}, edge_flags};
            IDX_TIMER:  rd_mux = timer;
            IDX_CMP:    rd_mux = cmp;
            IDX_STATUS: rd_mux = {{(XLEN-1){1'b0}}, match};
            default:    rd_mux = '0;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_reg    <= '0;
         sync1      <= '0;
         sync2      <= '0;
         prev       <= '0;
         edge_flags <= '0;
         timer      <= '0;
         cmp        <= '1;
         match      <= 1'b0;
         read_data  <= '0;
         hit        <= 1'b0;
      end else begin
         sync1      <= io_input_bus;
         sync2      <= sync1;
         prev       <= sync2;
         // A rise in the same cycle as a clear of that bit keeps the flag set.
         edge_flags <= (edge_flags & ~edge_clear) | rise;
         match      <= match_now | (match & ~match_clear);

         if (wr && idx == IDX_OUT) out_reg <= write_data[IO_WIDTH-1:0];
         if (wr && idx == IDX_CMP) cmp     <= write_data;
         if (wr && idx == IDX_TIMER) timer <= write_data;
         else                        timer <= timer + 1'b1;

         read_data <= rd_mux;
         hit       <= in_window;
      end
   end

endmodule
